// File: rtl/clock_time_keeper_if.sv
// clock_time_keeper_if: key, load and time-display signals of the clock time keeper.
interface clock_time_keeper_if;
  logic       key_mode;
  logic       key_inc;
  logic       load_en;
  logic [5:0] load_hour;
  logic [5:0] load_minute;
  logic [5:0] load_second;
  logic [5:0] hour;
  logic [5:0] minute;
  logic [5:0] second;
  logic [1:0] mode;
  logic       tick;
  logic       load_err;
  modport master (
    output key_mode, key_inc, load_en, load_hour, load_minute, load_second,
    input  hour, minute, second, mode, tick, load_err
  );
  modport slave (
    input  key_mode, key_inc, load_en, load_hour, load_minute, load_second,
    output hour, minute, second, mode, tick, load_err
  );
endinterface

// File: rtl/clock_time_keeper.sv
// clock_time_keeper: 24-hour HH:MM:SS counter with 1 Hz prescaler, debounced set keys and a checked load port.
module clock_time_keeper #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int DEB_CYCLES = 500_000
) (
  input logic               clk,
  input logic               rst,
  clock_time_keeper_if.slave bus
);
  localparam int PW = CLK_FREQ > 1 ? $clog2(CLK_FREQ) : 1;
  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam logic [PW-1:0] PRE_LAST = PW'(CLK_FREQ - 1);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);
  typedef enum logic [1:0] {RUN, SET_HOUR, SET_MIN, SET_SEC} mode_t;
  mode_t         r_mode, w_mode_nxt;
  logic [PW-1:0] r_pre, w_pre_nxt;
  logic [5:0]    r_hour, r_min, r_sec, w_hour_nxt, w_min_nxt, w_sec_nxt;
  logic          r_tick, r_err;
  logic [1:0]    r_s1, r_s2, r_lvl, r_lvl_d, w_pulse;
  logic [DW-1:0] r_cnt [2];
  logic          w_mode_p, w_inc_p, w_ok, w_ld, w_tick, w_inc;
  logic          w_swrap, w_mwrap, w_hinc, w_minc, w_sinc;
  assign w_pulse  = r_lvl & ~r_lvl_d;
  assign w_mode_p = w_pulse[0];
  assign w_inc_p  = w_pulse[1];
  // bit 0 = mode key, bit 1 = increment key
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1     <= '0;
      r_s2     <= '0;
      r_lvl    <= '0;
      r_lvl_d  <= '0;
      r_cnt[0] <= '0;
      r_cnt[1] <= '0;
    end else begin
      r_s1    <= {bus.key_inc, bus.key_mode};
      r_s2    <= r_s1;
      r_lvl_d <= r_lvl;
      for (int k = 0; k < 2; k++) begin
        r_cnt[k] <= (r_s2[k] == r_lvl[k] || r_cnt[k] == DEB_LAST) ? '0 : r_cnt[k] + DW'(1);
        if (r_s2[k] != r_lvl[k] && r_cnt[k] == DEB_LAST) r_lvl[k] <= r_s2[k];
      end
    end
  end
  // Any load_en, even a rejected one, owns the cycle: no tick or increment; a rejected load holds pre.
  always_comb begin
    w_ok       = bus.load_hour <= 6'd23 && bus.load_minute <= 6'd59 && bus.load_second <= 6'd59;
    w_ld       = bus.load_en && w_ok;
    w_tick     = r_mode == RUN && r_pre == PRE_LAST && !bus.load_en && !w_mode_p;
    w_inc      = w_inc_p && !w_mode_p && !bus.load_en && r_mode != RUN;
    w_swrap    = r_sec == 6'd59;
    w_mwrap    = r_min == 6'd59;
    w_hinc     = (w_inc && r_mode == SET_HOUR) || (w_tick && w_swrap && w_mwrap);
    w_minc     = (w_inc && r_mode == SET_MIN) || (w_tick && w_swrap);
    w_sinc     = (w_inc && r_mode == SET_SEC) || w_tick;
    w_hour_nxt = w_ld ? bus.load_hour : w_hinc ? (r_hour == 6'd23 ? 6'd0 : r_hour + 6'd1) : r_hour;
    w_min_nxt  = w_ld ? bus.load_minute : w_minc ? (w_mwrap ? 6'd0 : r_min + 6'd1) : r_min;
    w_sec_nxt  = w_ld ? bus.load_second : w_sinc ? (w_swrap ? 6'd0 : r_sec + 6'd1) : r_sec;
    w_mode_nxt = w_mode_p ? mode_t'(r_mode + 2'd1) : r_mode;
    w_pre_nxt  = (w_ld || r_mode != RUN || w_mode_p) ? '0 :
                 bus.load_en ? r_pre : r_pre == PRE_LAST ? '0 : r_pre + PW'(1);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mode <= RUN;
      r_pre  <= '0;
      r_hour <= '0;
      r_min  <= '0;
      r_sec  <= '0;
      r_tick <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_mode <= w_mode_nxt;
      r_pre  <= w_pre_nxt;
      r_hour <= w_hour_nxt;
      r_min  <= w_min_nxt;
      r_sec  <= w_sec_nxt;
      r_tick <= w_tick;
      r_err  <= bus.load_en && !w_ok;
    end
  end
  assign bus.hour     = r_hour;
  assign bus.minute   = r_min;
  assign bus.second   = r_sec;
  assign bus.mode     = r_mode;
  assign bus.tick     = r_tick;
  assign bus.load_err = r_err;
endmodule
